ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares one ram_memory instance between two requesters: port 0 is load/store, port 1 is instruction fetch.
- Sits between the core's memory ports and the RAM.
- Uses a valid/ready request handshake and returns a registered response one cycle after grant.
- Flags accesses whose address falls outside the RAM window instead of issuing them.

Parameters:
- BUS_WIDTH, 32, width of address and data.
- ADDR_BASE, 0, first word address of the RAM window; must match the RAM instance.
- MEM_SIZE, 256, RAM depth in words; must match the RAM instance.

Ports:
- clk  in  1  clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- req0_valid  in  1  port 0 request; addr/we/wdata held stable until accepted.
- req0_ready  out  1  port 0 granted this cycle (combinational).
- req0_we  in  1  1=write, 0=read.
- req0_addr  in  BUS_WIDTH  word address.
- req0_wdata  in  BUS_WIDTH  write data.
- rsp0_valid  out  1  port 0 response, one cycle pulse.
- rsp0_rdata  out  BUS_WIDTH  read data; 0 for writes and errors.
- rsp0_err  out  1  address was out of range.
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata, rsp1_err: identical set for port 1.
- ram_write_en  out  1  to RAM write_en.
- ram_addr_write  out  BUS_WIDTH  to RAM addr_write.
- ram_data_write  out  BUS_WIDTH  to RAM data_write.
- ram_addr_read  out  BUS_WIDTH  to RAM addr_read.
- ram_data_read  in  BUS_WIDTH  from RAM data_read, registered inside the RAM.

Behaviour:
- Clocking: clk, single domain. Reset: nreset, asynchronous active-low.
- Reset state: rsp*_valid=0, rsp*_err=0, rsp*_rdata=0, pending owner cleared, round-robin pointer=0.
- Reset mid-operation: any pending response is dropped and not replayed after reset.
- Grant (cycle T):
  - At most one port per cycle.
  - Without the macro, port 0 has fixed priority.
  - reqN_ready=1 only for the granted port, and only while reqN_valid=1.
- In-range check: (addr - ADDR_BASE) < MEM_SIZE, unsigned compare on BUS_WIDTH bits. Addresses below ADDR_BASE wrap and count as out of range.
- Granted in-range write, cycle T:
  - ram_write_en=1, ram_data_write=wdata.
  - ram_addr_write=addr and ram_addr_read=addr. Both must be driven because the RAM gates writes on the read address being in range.
- Granted in-range read, cycle T: ram_addr_read=addr, ram_write_en=0.
- Out of range, cycle T: ram_write_en=0, ram_addr_read=ADDR_BASE. The RAM is not touched.
- No grant in cycle T: ram_write_en=0, both RAM addresses=ADDR_BASE.
- Response (cycle T+1): latency is exactly 1.
  - rspN_valid=1 for the owning port only.
  - rdata=ram_data_read for an in-range read, otherwise 0.
  - err=1 if out of range.
  - Owner, we and err are registered at T.
- Throughput:
  - A new grant may occur in T+1 while the T response is presented, giving 1 access per cycle sustained.
  - Requesters must accept a response unconditionally; there is no rsp ready.
- State machine, 2 states:
  - IDLE -> RESP on any grant.
  - RESP -> RESP on a grant in the same cycle.
  - RESP -> IDLE with no grant.
  - rsp valid is asserted only in RESP.
- Read-after-write to the same address in consecutive grants returns the new data, because the RAM write lands at the end of T.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - 1-bit pointer selects the preferred port on conflict.
  - After any grant, the pointer moves to the other port.
  - Under continuous conflict, grants alternate 0,1,0,1.
- Undefined: fixed priority, port 0 always wins and port 1 may starve.

Decomposition:
- Shared package ram_arb_pkg:
  - State encoding (ARB_IDLE, ARB_RESP).
  - Port index constants (ARB_PORT_LSU=0, ARB_PORT_FETCH=1).
- Sub-module arb_grant_2: combinational grant logic plus the optional round-robin pointer register. The main module instantiates it once.

Test Plan:
- Reset then idle: all rsp outputs 0, ram_write_en=0, RAM addresses=ADDR_BASE.
- Port 0 writes 0xDEADBEEF to addr 5, then reads addr 5 -> rsp0_valid on each T+1, read returns rdata=0xDEADBEEF, err=0.
- Both ports read every cycle for 6 cycles:
  - Without the macro, only port 0 is granted.
  - With ARB_ROUND_ROBIN_EN, grants alternate starting at port 0, and each response goes to the correct port with correct data.
- Port 1 reads addr 256 (MEM_SIZE=256) -> rsp1_err=1, rdata=0, ram_write_en stays 0.
- Port 0 write to addr 300 -> rsp0_err=1 and RAM contents are unchanged (verify by reading addr 44=300 mod 256).
- Read granted, nreset pulsed low before T+1 -> no rsp_valid, state IDLE; after release, a read of addr 5 returns 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding and port indices for the RAM arbiter
package ram_arb_pkg;
    typedef enum logic {ARB_IDLE = 1'b0, ARB_RESP = 1'b1} arb_state_t;
    localparam logic ARB_PORT_LSU   = 1'b0;
    localparam logic ARB_PORT_FETCH = 1'b1;
endpackage

// File: rtl/arb_grant_2.sv
// arb_grant_2: two-port grant select; round-robin pointer when ARB_ROUND_ROBIN_EN is defined, else port 0 fixed priority
module arb_grant_2
    import ram_arb_pkg::*;
(
    input  logic clk,
    input  logic nreset,
    input  logic valid0,
    input  logic valid1,
    output logic grant,
    output logic sel
);
    assign grant = valid0 | valid1;
`ifdef ARB_ROUND_ROBIN_EN
    logic ptr;
    assign sel = (valid0 && valid1) ? ptr : (valid1 ? ARB_PORT_FETCH : ARB_PORT_LSU);
    // after each grant prefer the port that was not just served
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) ptr <= ARB_PORT_LSU;
        else if (grant) ptr <= ~sel;
    end
`else
    logic unused_clk;
    assign unused_clk = clk ^ nreset;
    assign sel = (!valid0 && valid1) ? ARB_PORT_FETCH : ARB_PORT_LSU;
`endif
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM between load/store and fetch ports, 1-cycle registered response; ARB_ROUND_ROBIN_EN selects round-robin
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int BUS_WIDTH = 32,
    parameter int ADDR_BASE = 0,
    parameter int MEM_SIZE  = 256
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic                 req0_we,
    input  logic [BUS_WIDTH-1:0] req0_addr,
    input  logic [BUS_WIDTH-1:0] req0_wdata,
    output logic                 rsp0_valid,
    output logic [BUS_WIDTH-1:0] rsp0_rdata,
    output logic                 rsp0_err,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic                 req1_we,
    input  logic [BUS_WIDTH-1:0] req1_addr,
    input  logic [BUS_WIDTH-1:0] req1_wdata,
    output logic                 rsp1_valid,
    output logic [BUS_WIDTH-1:0] rsp1_rdata,
    output logic                 rsp1_err,
    output logic                 ram_write_en,
    output logic [BUS_WIDTH-1:0] ram_addr_write,
    output logic [BUS_WIDTH-1:0] ram_data_write,
    output logic [BUS_WIDTH-1:0] ram_addr_read,
    input  logic [BUS_WIDTH-1:0] ram_data_read
);
    logic grant, sel, we, in_range, resp, owner, r_we, r_err;
    logic [BUS_WIDTH-1:0] addr, wdata, base, rdata;
    arb_state_t state, state_next;

    arb_grant_2 u_grant (
        .clk(clk), .nreset(nreset), .valid0(req0_valid), .valid1(req1_valid),
        .grant(grant), .sel(sel)
    );

    assign base       = BUS_WIDTH'(ADDR_BASE);
    assign addr       = sel ? req1_addr : req0_addr;
    assign wdata      = sel ? req1_wdata : req0_wdata;
    assign we         = sel ? req1_we : req0_we;
    assign in_range   = (addr - base) < BUS_WIDTH'(MEM_SIZE);
    assign req0_ready = grant && sel == ARB_PORT_LSU;
    assign req1_ready = grant && sel == ARB_PORT_FETCH;

    // next state and RAM drive; idle or out-of-range parks both addresses at the window base
    always_comb begin
        state_next     = ARB_IDLE;
        ram_write_en   = 1'b0;
        ram_addr_write = base;
        ram_addr_read  = base;
        ram_data_write = '0;
        if (grant) begin
            state_next = ARB_RESP;
            if (in_range) begin
                ram_addr_read = addr;
                if (we) begin
                    ram_write_en   = 1'b1;
                    ram_addr_write = addr;
                    ram_data_write = wdata;
                end
            end
        end
    end

    // state plus owner/we/err of the granted access, consumed one cycle later
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= ARB_IDLE;
            owner <= ARB_PORT_LSU;
            r_we  <= 1'b0;
            r_err <= 1'b0;
        end else begin
            state <= state_next;
            if (grant) begin
                owner <= sel;
                r_we  <= we;
                r_err <= !in_range;
            end
        end
    end

    assign resp       = state == ARB_RESP;
    assign rdata      = (resp && !r_we && !r_err) ? ram_data_read : '0;
    assign rsp0_valid = resp && owner == ARB_PORT_LSU;
    assign rsp1_valid = resp && owner == ARB_PORT_FETCH;
    assign rsp0_rdata = rsp0_valid ? rdata : '0;
    assign rsp1_rdata = rsp1_valid ? rdata : '0;
    assign rsp0_err   = rsp0_valid && r_err;
    assign rsp1_err   = rsp1_valid && r_err;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: vector table plus scoreboard bench for ram_arbiter with a behavioural RAM
module tb_ram_arbiter;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0, nreset = 1'b0;
    logic req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
    logic [31:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
    logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, ram_write_en;
    logic [31:0] rsp0_rdata, rsp1_rdata, ram_addr_write, ram_data_write, ram_addr_read, ram_data_read;
    logic [31:0] mem [256];

    typedef struct { logic p; logic we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; logic err; } vec_t;
    typedef struct { logic p; logic [31:0] rdata; logic err; int due; } exp_t;
    vec_t vecs [12];
    exp_t sb [$];
    int cyc = 0, total = 0, passes = 0;
    logic rr_ptr = 1'b0;

    ram_arbiter dut (
        .clk(clk), .nreset(nreset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .ram_write_en(ram_write_en), .ram_addr_write(ram_addr_write), .ram_data_write(ram_data_write),
        .ram_addr_read(ram_addr_read), .ram_data_read(ram_data_read)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM: cleared by reset, registered read, write gated on read address in range
    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            ram_data_read <= '0;
        end else begin
            if (ram_write_en && ram_addr_read < 256) mem[ram_addr_write[7:0]] <= ram_data_write;
            ram_data_read <= (ram_addr_read < 256) ? mem[ram_addr_read[7:0]] : '0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        else passes++;
    endtask

    // response monitor: pops the scoreboard exactly on the due cycle
    always @(negedge clk) begin
        if (nreset) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, e.p ? 32'd2 : 32'd1);
                chk("rsp0_rdata", rsp0_rdata, e.p ? 32'd0 : e.rdata);
                chk("rsp1_rdata", rsp1_rdata, e.p ? e.rdata : 32'd0);
                chk("rsp_err", {30'd0, rsp1_err, rsp0_err}, e.err ? (e.p ? 32'd2 : 32'd1) : 32'd0);
            end else begin
                chk("rsp_idle", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
            end
        end
    end

    task automatic issue(input logic p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
        logic ir;
        ir = a < 256;
        req0_valid = !p; req0_we = we; req0_addr = a; req0_wdata = wd;
        req1_valid = p;  req1_we = we; req1_addr = a; req1_wdata = wd;
        @(negedge clk);
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, !p});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, p});
        chk("ram_write_en", {31'd0, ram_write_en}, {31'd0, we && ir});
        chk("ram_addr_read", ram_addr_read, ir ? a : 32'd0);
        chk("ram_addr_write", ram_addr_write, (we && ir) ? a : 32'd0);
        if (we && ir) chk("ram_data_write", ram_data_write, wd);
        sb.push_back('{p, exp_rd, exp_err, cyc + 1});
        rr_ptr = ~p;
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'd5,          32'hDEADBEEF, 32'd0,        1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'd5,          32'd0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'd256,        32'd0,        32'd0,        1'b1};
        vecs[3]  = '{1'b0, 1'b1, 32'd300,        32'h0BADF00D, 32'd0,        1'b1};
        vecs[4]  = '{1'b0, 1'b0, 32'd44,         32'd0,        32'd0,        1'b0};
        vecs[5]  = '{1'b1, 1'b1, 32'd10,         32'h1111,     32'd0,        1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'd20,         32'h2222,     32'd0,        1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'd5,          32'd0,        32'hDEADBEEF, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 32'd255,        32'hFFFF0000, 32'd0,        1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'd255,        32'd0,        32'hFFFF0000, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'hFFFFFFFF,   32'd0,        32'd0,        1'b1};
        vecs[11] = '{1'b1, 1'b0, 32'd10,         32'd0,        32'h1111,     1'b0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp", {rsp1_valid, rsp0_valid, rsp1_err, rsp0_err, ram_write_en}, 32'd0);
        chk("reset_rdata", rsp0_rdata | rsp1_rdata, 32'd0);
        chk("reset_addr", ram_addr_read | ram_addr_write, 32'd0);
        nreset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++)
            issue(vecs[i].p, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err);
        req0_valid = 1; req0_we = 0; req0_addr = 32'd20;
        req1_valid = 1; req1_we = 0; req1_addr = 32'd10;
        for (int i = 0; i < 6; i++) begin
            logic g;
            @(negedge clk);
            g = RR ? rr_ptr : 1'b0;
            chk("conflict_ready0", {31'd0, req0_ready}, {31'd0, !g});
            chk("conflict_ready1", {31'd0, req1_ready}, {31'd0, g});
            chk("conflict_addr", ram_addr_read, g ? 32'd10 : 32'd20);
            sb.push_back('{g, g ? 32'h1111 : 32'h2222, 1'b0, cyc + 1});
            rr_ptr = ~g;
            @(posedge clk); #1;
        end
        req0_valid = 0; req1_valid = 0;
        repeat (2) @(posedge clk); #1;
        req0_valid = 1; req0_we = 0; req0_addr = 32'd5;
        @(negedge clk);
        chk("midreset_ready0", {31'd0, req0_ready}, 32'd1);
        #2;
        nreset = 0; req0_valid = 0;
        @(posedge clk); #1;
        chk("midreset_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        @(negedge clk); #1;
        nreset = 1;
        repeat (2) @(negedge clk);
        chk("after_reset_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        @(posedge clk); #1;
        issue(1'b0, 1'b0, 32'd5, 32'd0, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
